ps2_keyboard: RTL
=================

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 rst_n  input  1  asynchronous active-low reset.
REQ-002 clk28  input  1  28 MHz system clock; the only clock.
REQ-003 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk28.
REQ-004 ps2_dat  input  1  raw PS/2 data line, asynchronous to clk28.
REQ-005 addr_hi  input  8  CPU address bits 15:8, used as matrix row select (0 = row selected).
REQ-006 kd  output  5  ZX keyboard column data, active-low (0 = key pressed); feeds the port #FE reader.
REQ-007 key_magic  output  1  high while F12 is held.
REQ-008 key_reset  output  1  high while Ctrl, Alt and Delete are all held.
REQ-009 frame_err  output  1  one-cycle pulse on a parity error, stop-bit error or timeout.

Function
REQ-010 ps2_clk and ps2_dat SHALL each pass a 2-FF synchronizer.
REQ-011 The synchronized ps2_clk SHALL be debounced: its filtered state changes only after 8 consecutive identical samples.
REQ-012 The receiver SHALL sample ps2_dat on each falling edge of the filtered clock.
REQ-013 Receiver FSM states and transitions:
- IDLE: a sampled 0 (start bit) -> DATA.
- DATA: shift in 8 bits, LSB first -> PARITY.
- PARITY: capture the parity bit -> STOP.
- STOP: a sampled 1 with odd parity OK -> emit the byte with a one-cycle valid -> IDLE; otherwise pulse frame_err -> IDLE.
REQ-014 Timeout: in any state other than IDLE, 28000 clk28 cycles (1 ms) with no falling edge SHALL force IDLE, pulse frame_err and discard the partial byte.
REQ-015 Decoder, prefix bytes:
- 0xE0 sets the ext flag.
- 0xF0 sets the rel flag.
- Both flags apply to the next non-prefix byte and are cleared after it is processed.
REQ-016 Decoder, key bytes: a non-prefix byte is looked up with {ext, byte}.
- Mapped key: its matrix bit is set on press (rel=0) and cleared on release (rel=1).
- Unmapped code: ignored.
REQ-017 Matrix SHALL be 8 rows x 5 columns, stored internally active-high. Column 0 is listed first in each row:
- row0 (A8): CS Z X C V
- row1 (A9): A S D F G
- row2 (A10): Q W E R T
- row3 (A11): 1 2 3 4 5
- row4 (A12): 0 9 8 7 6
- row5 (A13): P O I U Y
- row6 (A14): Enter L K J H
- row7 (A15): Space SS M N B
REQ-018 Host-key mapping:
- Left Shift (0x12) = CS.
- Right Shift (0x59) and Left Ctrl (0x14) = SS.
- Backspace (0x66) = CS+0.
- E0-arrow keys Left/Down/Up/Right = CS+5/6/7/8.
REQ-019 Composite keys (REQ-018) SHALL be held in separate flags and ORed into the matrix at readout, so releasing one never clears a key still held directly.
REQ-020 Receiving byte 0xAA (keyboard BAT pass) SHALL clear the whole matrix, all composite flags and the magic/reset state.
REQ-021 kd SHALL be the bitwise NOT of the OR of all rows whose addr_hi bit is 0, registered, with 1 clk28 latency from an addr_hi change. addr_hi = 0xFF yields kd = 5'b11111.
REQ-022 key_magic tracks F12 (0x07); key_reset = ctrl & alt (0x11) & E0 0x71; both registered.
REQ-023 A byte completing in the same cycle as a timeout SHALL be discarded, and the timeout SHALL be reported.

Reset
REQ-024 On rst_n low, all registers SHALL clear asynchronously to the following values:
- kd = 5'b11111; key_magic = 0; key_reset = 0; frame_err = 0.
- Matrix, composite flags, ext and rel cleared.
- FSM = IDLE; timeout counter = 0.
REQ-025 A reset mid-frame SHALL discard the partial byte; reception resumes at the next start bit.

Structure
REQ-026 Scancode constants, the {ext, code} -> (row, column) mapping function and the FSM state enum SHALL live in package common.
REQ-027 One sub-module, ps2_rx (synchronizer, filter, FSM, timeout), SHALL output a byte plus a valid pulse and an error pulse; the decoder and matrix stay in ps2_keyboard.

Verification
REQ-028 Frame 0x1C (A), then addr_hi=0xFD -> kd=5'b11110; then frames F0 1C -> kd=5'b11111.
REQ-029 Press 0x12 (LShift) and 0x29 (Space); addr_hi=0x7E -> kd=5'b11110; addr_hi=0xFE -> kd=5'b11110; addr_hi=0x7F -> kd=5'b11110.
REQ-030 Press 0x66 (Backspace) and 0x12 (LShift), release 0x66; addr_hi=0xFE -> kd=5'b11110 (CS still held); addr_hi=0xEF -> kd=5'b11111.
REQ-031 Frame 0x1C with a bad parity bit -> frame_err pulses once and the matrix is unchanged; stopping mid-frame for 1 ms -> frame_err pulses and the next good frame decodes correctly.
REQ-032 Press 14, 11, E0 71 -> key_reset=1; release E0 71 -> key_reset=0; press 07 -> key_magic=1; frame 0xAA -> key_magic=0 and kd=5'b11111 for every addr_hi.
REQ-033 Assert rst_n low during bit 4 of a frame -> all outputs at reset values; the next complete frame 0x5A (Enter) with addr_hi=0xBF -> kd=5'b11110.

Source files
------------

// File: rtl/common.sv
// Shared constants, FSM state type and scancode-to-matrix mapping for the PS/2 keyboard.
package common;

    localparam int unsigned TimeoutCycles = 28000;  // 1 ms at 28 MHz
    localparam int unsigned TmoW          = 15;
    localparam int unsigned FilterLen     = 8;

    localparam logic [7:0] CodeExt  = 8'hE0;
    localparam logic [7:0] CodeRel  = 8'hF0;
    localparam logic [7:0] CodeBat  = 8'hAA;
    localparam logic [7:0] CodeF12  = 8'h07;
    localparam logic [7:0] CodeLAlt = 8'h11;
    localparam logic [7:0] CodeDel  = 8'h71;  // E0-prefixed

    // Composite flag indices; these keys drive more than one matrix bit or share a bit
    localparam int unsigned CompRShift = 0;
    localparam int unsigned CompLCtrl  = 1;
    localparam int unsigned CompBksp   = 2;
    localparam int unsigned CompLeft   = 3;
    localparam int unsigned CompDown   = 4;
    localparam int unsigned CompUp     = 5;
    localparam int unsigned CompRight  = 6;
    localparam int unsigned NumComp    = 7;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

    typedef enum logic [1:0] {KindNone, KindMatrix, KindComp} key_kind_e;

    // For KindComp, col carries the composite flag index
    typedef struct packed {
        key_kind_e  kind;
        logic [2:0] row;
        logic [2:0] col;
    } key_map_t;

    function automatic key_map_t mk(input key_kind_e k, input int unsigned r, input int unsigned c);
        key_map_t m;
        m.kind = k;
        m.row  = 3'(r);
        m.col  = 3'(c);
        return m;
    endfunction

    function automatic key_map_t key_map(input logic ext, input logic [7:0] code);
        key_map_t m;
        m = mk(KindNone, 0, 0);
        case ({ext, code})
            9'h012: m = mk(KindMatrix, 0, 0);   9'h01A: m = mk(KindMatrix, 0, 1);
            9'h022: m = mk(KindMatrix, 0, 2);   9'h021: m = mk(KindMatrix, 0, 3);
            9'h02A: m = mk(KindMatrix, 0, 4);
            9'h01C: m = mk(KindMatrix, 1, 0);   9'h01B: m = mk(KindMatrix, 1, 1);
            9'h023: m = mk(KindMatrix, 1, 2);   9'h02B: m = mk(KindMatrix, 1, 3);
            9'h034: m = mk(KindMatrix, 1, 4);
            9'h015: m = mk(KindMatrix, 2, 0);   9'h01D: m = mk(KindMatrix, 2, 1);
            9'h024: m = mk(KindMatrix, 2, 2);   9'h02D: m = mk(KindMatrix, 2, 3);
            9'h02C: m = mk(KindMatrix, 2, 4);
            9'h016: m = mk(KindMatrix, 3, 0);   9'h01E: m = mk(KindMatrix, 3, 1);
            9'h026: m = mk(KindMatrix, 3, 2);   9'h025: m = mk(KindMatrix, 3, 3);
            9'h02E: m = mk(KindMatrix, 3, 4);
            9'h045: m = mk(KindMatrix, 4, 0);   9'h046: m = mk(KindMatrix, 4, 1);
            9'h03E: m = mk(KindMatrix, 4, 2);   9'h03D: m = mk(KindMatrix, 4, 3);
            9'h036: m = mk(KindMatrix, 4, 4);
            9'h04D: m = mk(KindMatrix, 5, 0);   9'h044: m = mk(KindMatrix, 5, 1);
            9'h043: m = mk(KindMatrix, 5, 2);   9'h03C: m = mk(KindMatrix, 5, 3);
            9'h035: m = mk(KindMatrix, 5, 4);
            9'h05A: m = mk(KindMatrix, 6, 0);   9'h04B: m = mk(KindMatrix, 6, 1);
            9'h042: m = mk(KindMatrix, 6, 2);   9'h03B: m = mk(KindMatrix, 6, 3);
            9'h033: m = mk(KindMatrix, 6, 4);
            9'h029: m = mk(KindMatrix, 7, 0);   9'h03A: m = mk(KindMatrix, 7, 2);
            9'h031: m = mk(KindMatrix, 7, 3);   9'h032: m = mk(KindMatrix, 7, 4);
            9'h059: m = mk(KindComp, 0, CompRShift);
            9'h014: m = mk(KindComp, 0, CompLCtrl);
            9'h066: m = mk(KindComp, 0, CompBksp);
            9'h16B: m = mk(KindComp, 0, CompLeft);
            9'h172: m = mk(KindComp, 0, CompDown);
            9'h175: m = mk(KindComp, 0, CompUp);
            9'h174: m = mk(KindComp, 0, CompRight);
            default: ;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: line synchronizers, clock debounce, frame FSM and 1 ms timeout.
module ps2_rx
    import common::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       err_o
);

    logic [1:0]      clk_sync_q, dat_sync_q;
    logic            clk_filt_q, clk_filt_d;
    logic [2:0]      filt_cnt_q, filt_cnt_d;
    rx_state_e       state_q, state_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      shift_q, shift_d;
    logic            par_q, par_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic [7:0]      byte_q, byte_d;
    logic            valid_q, valid_d, err_q, err_d;
    logic            fall, dat, timeout;

    assign dat     = dat_sync_q[1];
    assign byte_o  = byte_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

    // Debounce: the filtered clock follows only after FilterLen identical differing samples
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (filt_cnt_q == 3'(FilterLen - 1)) begin
                clk_filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + 3'd1;
            end
        end
    end

    assign fall = clk_filt_q & ~clk_filt_d;

    // Frame FSM; a timeout wins over a byte completing in the same cycle
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        tmo_d     = '0;
        byte_d    = byte_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        timeout   = (state_q != StIdle) && (tmo_q == TmoW'(TimeoutCycles - 1));
        if (timeout) begin
            state_d = StIdle;
            err_d   = 1'b1;
        end else begin
            if (state_q != StIdle && !fall) begin
                tmo_d = tmo_q + 1'b1;
            end
            if (fall) begin
                case (state_q)
                    StIdle: begin
                        if (!dat) begin
                            state_d   = StData;
                            bit_cnt_d = '0;
                        end
                    end
                    StData: begin
                        shift_d   = {dat, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = StParity;
                        end
                    end
                    StParity: begin
                        par_d   = dat;
                        state_d = StStop;
                    end
                    StStop: begin
                        state_d = StIdle;
                        if (dat && (^{shift_q, par_q})) begin
                            byte_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    // State registers; line synchronizers idle high like the bus
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            byte_q     <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
            dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            byte_q     <= byte_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard to ZX Spectrum 8x5 key matrix with magic/reset key detection.
module ps2_keyboard
    import common::*;
(
    input  logic       rst_n,
    input  logic       clk28,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] addr_hi,
    output logic [4:0] kd,
    output logic       key_magic,
    output logic       key_reset,
    output logic       frame_err
);

    logic [7:0]         rx_byte;
    logic               rx_valid;
    logic [7:0][4:0]    matrix_q, matrix_d, eff;
    logic [NumComp-1:0] comp_q, comp_d;
    logic               ext_q, ext_d, rel_q, rel_d;
    logic               magic_q, magic_d, alt_q, alt_d, del_q, del_d, reset_q, reset_d;
    logic [4:0]         kd_q, kd_d, col_or;
    key_map_t           km;

    ps2_rx u_rx (
        .clk_i     (clk28),
        .rst_ni    (rst_n),
        .ps2_clk_i (ps2_clk),
        .ps2_dat_i (ps2_dat),
        .byte_o    (rx_byte),
        .valid_o   (rx_valid),
        .err_o     (frame_err)
    );

    assign km        = key_map(ext_q, rx_byte);
    assign kd        = kd_q;
    assign key_magic = magic_q;
    assign key_reset = reset_q;

    // Scancode decoder: prefix flags, matrix/composite updates, BAT clears everything
    always_comb begin
        matrix_d = matrix_q;
        comp_d   = comp_q;
        ext_d    = ext_q;
        rel_d    = rel_q;
        magic_d  = magic_q;
        alt_d    = alt_q;
        del_d    = del_q;
        if (rx_valid) begin
            if (rx_byte == CodeExt) begin
                ext_d = 1'b1;
            end else if (rx_byte == CodeRel) begin
                rel_d = 1'b1;
            end else if (rx_byte == CodeBat) begin
                matrix_d = '0;
                comp_d   = '0;
                ext_d    = 1'b0;
                rel_d    = 1'b0;
                magic_d  = 1'b0;
                alt_d    = 1'b0;
                del_d    = 1'b0;
            end else begin
                ext_d = 1'b0;
                rel_d = 1'b0;
                if (km.kind == KindMatrix) begin
                    matrix_d[km.row][km.col] = ~rel_q;
                end else if (km.kind == KindComp) begin
                    comp_d[km.col] = ~rel_q;
                end
                if ({ext_q, rx_byte} == {1'b0, CodeF12}) magic_d = ~rel_q;
                if ({ext_q, rx_byte} == {1'b0, CodeLAlt}) alt_d = ~rel_q;
                if ({ext_q, rx_byte} == {1'b1, CodeDel}) del_d = ~rel_q;
            end
        end
        reset_d = comp_d[CompLCtrl] & alt_d & del_d;
    end

    // Readout: composites ORed onto the stored matrix, then rows selected by low address bits
    always_comb begin
        eff = matrix_q;
        eff[0][0] = matrix_q[0][0] | comp_q[CompBksp] | comp_q[CompLeft] | comp_q[CompDown]
                  | comp_q[CompUp] | comp_q[CompRight];
        eff[7][1] = matrix_q[7][1] | comp_q[CompRShift] | comp_q[CompLCtrl];
        eff[4][0] = matrix_q[4][0] | comp_q[CompBksp];
        eff[3][4] = matrix_q[3][4] | comp_q[CompLeft];
        eff[4][4] = matrix_q[4][4] | comp_q[CompDown];
        eff[4][3] = matrix_q[4][3] | comp_q[CompUp];
        eff[4][2] = matrix_q[4][2] | comp_q[CompRight];
        col_or = '0;
        for (int r = 0; r < 8; r++) begin
            if (!addr_hi[r]) col_or = col_or | eff[r];
        end
        kd_d = ~col_or;
    end

    // State registers
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            matrix_q <= '0;
            comp_q   <= '0;
            ext_q    <= 1'b0;
            rel_q    <= 1'b0;
            magic_q  <= 1'b0;
            alt_q    <= 1'b0;
            del_q    <= 1'b0;
            reset_q  <= 1'b0;
            kd_q     <= 5'b11111;
        end else begin
            matrix_q <= matrix_d;
            comp_q   <= comp_d;
            ext_q    <= ext_d;
            rel_q    <= rel_d;
            magic_q  <= magic_d;
            alt_q    <= alt_d;
            del_q    <= del_d;
            reset_q  <= reset_d;
            kd_q     <= kd_d;
        end
    end

endmodule
